// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Pipeline hazard controller. Merges per-stage stall requests
//            into a cascaded stall vector, issues redirect flushes and defers
//            any flush whose source stage is held. Counts stall and flush
//            events and runs a watchdog that flags a long stall.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            stallreq[STAGES]    - stage i cannot advance this cycle
//            flushreq[STAGES]    - stage j redirects, kill stages 0..j-1
//            cnt_clr             - clear both performance counters
//            stall[STAGES]       - stage register i holds
//            flush[STAGES]       - stage register i loads a bubble
//            stall_cycles, flush_count - saturating event counters
//            hang                - sticky watchdog flag
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int STAGES  = 5,
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq,
    input  logic [STAGES-1:0] flushreq,
    input  logic              cnt_clr,
    output logic [STAGES-1:0] stall,
    output logic [STAGES-1:0] flush,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count,
    output logic              hang
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [STAGES-1:1] r_pend_q;
    logic [STAGES-1:1] w_pend_d;
    logic [STAGES-1:0] w_stall;
    logic [STAGES-1:0] w_req;
    logic [STAGES-1:0] w_kill;
    logic [STAGES-1:0] w_flush;
    logic              w_src_stalled;
    logic              w_issue;
    logic              w_stall_any;
    logic [CNT_W-1:0]  r_stall_cycles_q;
    logic [CNT_W-1:0]  w_stall_cycles_d;
    logic [CNT_W-1:0]  r_flush_count_q;
    logic [CNT_W-1:0]  w_flush_count_d;

    // Stall merge: a stage holds if it or any older stage requests a stall.
    always_comb begin
        w_stall = '0;
        if (!rst) begin
            w_stall[STAGES-1] = stallreq[STAGES-1];
            for (int i = STAGES - 2; i >= 0; i--) begin
                w_stall[i] = w_stall[i+1] | stallreq[i];
            end
        end
    end

    assign w_stall_any = |w_stall;

    // Flush source selection. Pending flushes are merged with new requests so
    // a deferred flush re-issues by itself, and a re-request in the release
    // cycle collapses onto the same single flush.
    always_comb begin
        w_req         = flushreq | {r_pend_q, 1'b0};
        w_req[0]      = 1'b0;
        w_src_stalled = 1'b0;
        // Ascending scan: the highest requesting stage decides.
        for (int i = 1; i < STAGES; i++) begin
            if (w_req[i]) begin
                w_src_stalled = w_stall[i];
            end
        end
        w_issue = (|w_req) & ~w_src_stalled & ~rst;
        // Stage i is killed when any stage above it is a flush source.
        w_kill  = '0;
        for (int i = STAGES - 2; i >= 0; i--) begin
            w_kill[i] = w_kill[i+1] | w_req[i+1];
        end
        w_flush = w_issue ? w_kill : '0;
    end

    // An issued flush kills every lower stage, so all pending bits retire.
    always_comb begin
        w_pend_d = r_pend_q | flushreq[STAGES-1:1];
        if (w_issue) begin
            w_pend_d = '0;
        end
    end

    always_comb begin
        w_stall_cycles_d = r_stall_cycles_q;
        w_flush_count_d  = r_flush_count_q;
        if (cnt_clr) begin
            w_stall_cycles_d = '0;
            w_flush_count_d  = '0;
        end else begin
            if (w_stall_any && (r_stall_cycles_q != c_CNT_MAX)) begin
                w_stall_cycles_d = r_stall_cycles_q + CNT_W'(1);
            end
            if (w_issue && (r_flush_count_q != c_CNT_MAX)) begin
                w_flush_count_d = r_flush_count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend_q         <= '0;
            r_stall_cycles_q <= '0;
            r_flush_count_q  <= '0;
        end else begin
            r_pend_q         <= w_pend_d;
            r_stall_cycles_q <= w_stall_cycles_d;
            r_flush_count_q  <= w_flush_count_d;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_wdog
            localparam int               RUN_W     = $clog2(TIMEOUT + 1);
            localparam logic [RUN_W-1:0] c_RUN_MAX = RUN_W'(TIMEOUT);

            logic [RUN_W-1:0] r_run_q;
            logic [RUN_W-1:0] w_run_d;
            logic             r_hang_q;
            logic             w_hang_d;

            always_comb begin
                w_run_d  = '0;
                w_hang_d = r_hang_q;
                if (w_stall_any) begin
                    w_run_d = r_run_q;
                    if (r_run_q != c_RUN_MAX) begin
                        w_run_d = r_run_q + RUN_W'(1);
                    end
                    // This edge completes the TIMEOUT-th stalled cycle.
                    if (r_run_q >= c_RUN_MAX - RUN_W'(1)) begin
                        w_hang_d = 1'b1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_run_q  <= '0;
                    r_hang_q <= 1'b0;
                end else begin
                    r_run_q  <= w_run_d;
                    r_hang_q <= w_hang_d;
                end
            end

            assign hang = r_hang_q;
        end else begin : g_no_wdog
            assign hang = 1'b0;
        end
    endgenerate

    assign stall        = w_stall;
    assign flush        = w_flush;
    assign stall_cycles = r_stall_cycles_q;
    assign flush_count  = r_flush_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Self-checking bench for pipe_ctrl. One instance with a 4-bit
//            counter and TIMEOUT=8, a second with 32-bit counters and the
//            watchdog disabled, both driven from the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] stallreq;
    logic [4:0] flushreq;
    logic       cnt_clr;
    logic [4:0] stall, flush, stall_nw, flush_nw;
    logic [3:0] sc, fc;
    logic [31:0] sc_nw, fc_nw;
    logic       hang, hang_nw;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [4:0] m_pend;
    int         m_sc, m_fc, m_sc_nw, m_fc_nw, m_run;
    logic       m_hang;
    logic [4:0] e_stall, e_flush;
    bit         e_iss;

    pipe_ctrl #(.STAGES(5), .CNT_W(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .stallreq(stallreq), .flushreq(flushreq),
        .cnt_clr(cnt_clr), .stall(stall), .flush(flush),
        .stall_cycles(sc), .flush_count(fc), .hang(hang)
    );

    pipe_ctrl #(.STAGES(5), .CNT_W(32), .TIMEOUT(0)) dut_nw (
        .clk(clk), .rst(rst), .stallreq(stallreq), .flushreq(flushreq),
        .cnt_clr(cnt_clr), .stall(stall_nw), .flush(flush_nw),
        .stall_cycles(sc_nw), .flush_count(fc_nw), .hang(hang_nw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected combinational outputs from the current inputs and model pend.
    function automatic void model_eval();
        int k;
        int j;
        logic [4:0] req;
        k = -1;
        j = -1;
        for (int i = 0; i < 5; i++) if (stallreq[i]) k = i;
        req = (flushreq | m_pend) & 5'b11110;
        for (int i = 1; i < 5; i++) if (req[i]) j = i;
        if (rst) begin
            e_stall = 5'd0;
            e_flush = 5'd0;
            e_iss   = 1'b0;
        end else begin
            e_stall = 5'((1 << (k + 1)) - 1);
            e_iss   = (j > 0) && (k < j);
            e_flush = e_iss ? 5'((1 << j) - 1) : 5'd0;
        end
    endfunction

    task automatic set_in(input logic [4:0] s, input logic [4:0] f,
                          input logic c, input logic r);
        stallreq = s;
        flushreq = f;
        cnt_clr  = c;
        rst      = r;
        #1;
        model_eval();
    endtask

    // Advance one clock edge and step the model alongside it.
    task automatic tick();
        model_eval();
        @(posedge clk);
        if (rst) begin
            m_pend = 0; m_sc = 0; m_fc = 0; m_sc_nw = 0; m_fc_nw = 0;
            m_run = 0; m_hang = 1'b0;
        end else begin
            m_pend = e_iss ? 5'd0 : (m_pend | (flushreq & 5'b11110));
            if (cnt_clr) begin
                m_sc = 0; m_fc = 0; m_sc_nw = 0; m_fc_nw = 0;
            end else begin
                if (e_stall != 0) begin
                    if (m_sc < 15) m_sc++;
                    m_sc_nw++;
                end
                if (e_iss) begin
                    if (m_fc < 15) m_fc++;
                    m_fc_nw++;
                end
            end
            if (e_stall != 0) begin
                if (m_run < 8) m_run++;
            end else begin
                m_run = 0;
            end
            if (m_run >= 8) m_hang = 1'b1;
        end
        #1;
        model_eval();
    endtask

    task automatic test_reset();
        for (int n = 0; n < 2; n++) begin
            set_in(5'($urandom), 5'($urandom), 1'b0, 1'b1);
            checks++; if (stall !== 5'd0) begin errors++; $display("FAIL reset_stall: got %b expected 00000", stall); end
            checks++; if (flush !== 5'd0) begin errors++; $display("FAIL reset_flush: got %b expected 00000", flush); end
            tick();
        end
        checks++; if (sc !== 4'd0 || fc !== 4'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", sc, fc); end
        checks++; if (hang !== 1'b0 || hang_nw !== 1'b0) begin errors++; $display("FAIL reset_hang: got %b/%b expected 0/0", hang, hang_nw); end
        checks++; if (dut.r_pend_q !== 4'd0) begin errors++; $display("FAIL reset_pend: got %b expected 0000", dut.r_pend_q); end
        set_in(5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic test_stall_merge();
        logic [4:0] pats [4];
        logic [4:0] exps [4];
        logic [4:0] s;
        pats = '{5'b00001, 5'b01000, 5'b01001, 5'b00000};
        exps = '{5'b00001, 5'b01111, 5'b01111, 5'b00000};
        for (int n = 0; n < 4; n++) begin
            set_in(pats[n], 5'd0, 1'b0, 1'b0);
            checks++; if (stall !== exps[n]) begin errors++; $display("FAIL merge_fixed: req %b got %b expected %b", pats[n], stall, exps[n]); end
            tick();
        end
        for (int n = 0; n < 16; n++) begin
            s = 5'($urandom);
            set_in(s, 5'd0, 1'b0, 1'b0);
            checks++; if (stall !== e_stall || stall_nw !== e_stall) begin errors++; $display("FAIL merge_rand: req %b got %b/%b expected %b", s, stall, stall_nw, e_stall); end
            checks++; if (flush !== 5'd0) begin errors++; $display("FAIL merge_noflush: got %b expected 00000", flush); end
            tick();
        end
    endtask

    task automatic test_immediate_flush();
        set_in(5'd0, 5'd0, 1'b1, 1'b0);
        tick();
        set_in(5'd0, 5'b00100, 1'b0, 1'b0);
        checks++; if (flush !== 5'b00011) begin errors++; $display("FAIL imm_flush: got %b expected 00011", flush); end
        checks++; if (stall !== 5'd0) begin errors++; $display("FAIL imm_stall: got %b expected 00000", stall); end
        tick();
        checks++; if (fc !== 4'd1 || fc !== 4'(m_fc)) begin errors++; $display("FAIL imm_count: got %0d expected 1", fc); end
        checks++; if (dut.r_pend_q !== 4'd0) begin errors++; $display("FAIL imm_pend: got %b expected 0000", dut.r_pend_q); end
        set_in(5'd0, 5'd0, 1'b0, 1'b0);
        checks++; if (flush !== 5'd0) begin errors++; $display("FAIL imm_once: got %b expected 00000", flush); end
        tick();
    endtask

    task automatic test_deferred_flush();
        set_in(5'b01000, 5'b00100, 1'b0, 1'b0);
        checks++; if (flush !== 5'd0 || stall !== 5'b01111) begin errors++; $display("FAIL defer_first: got flush %b stall %b expected 00000 01111", flush, stall); end
        tick();
        for (int n = 0; n < 3; n++) begin
            set_in(5'b01000, 5'd0, 1'b0, 1'b0);
            checks++; if (flush !== 5'd0) begin errors++; $display("FAIL defer_hold: got %b expected 00000", flush); end
            checks++; if (dut.r_pend_q !== 4'b0010) begin errors++; $display("FAIL defer_pend: got %b expected 0010", dut.r_pend_q); end
            tick();
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0);
        checks++; if (flush !== 5'b00011) begin errors++; $display("FAIL defer_release: got %b expected 00011", flush); end
        tick();
        checks++; if (dut.r_pend_q !== 4'd0) begin errors++; $display("FAIL defer_pend_clr: got %b expected 0000", dut.r_pend_q); end
        checks++; if (flush !== 5'd0) begin errors++; $display("FAIL defer_once: got %b expected 00000", flush); end
        tick();
    endtask

    task automatic test_rerequest_supersede();
        int fc0;
        set_in(5'd0, 5'd0, 1'b1, 1'b0);
        tick();
        set_in(5'b01000, 5'b00100, 1'b0, 1'b0);
        tick();
        fc0 = m_fc;
        // Source re-asserts during the release cycle: one flush only.
        set_in(5'd0, 5'b00100, 1'b0, 1'b0);
        checks++; if (flush !== 5'b00011) begin errors++; $display("FAIL rereq_flush: got %b expected 00011", flush); end
        tick();
        checks++; if (fc !== 4'(fc0 + 1)) begin errors++; $display("FAIL rereq_count: got %0d expected %0d", fc, fc0 + 1); end
        set_in(5'd0, 5'd0, 1'b0, 1'b0);
        checks++; if (flush !== 5'd0) begin errors++; $display("FAIL rereq_once: got %b expected 00000", flush); end
        tick();
        // Stage 2 pending, then stage 4 requests while fully stalled.
        set_in(5'b01000, 5'b00100, 1'b0, 1'b0);
        tick();
        set_in(5'b10000, 5'b10000, 1'b0, 1'b0);
        checks++; if (flush !== 5'd0) begin errors++; $display("FAIL super_defer: got %b expected 00000", flush); end
        tick();
        set_in(5'd0, 5'd0, 1'b0, 1'b0);
        checks++; if (flush !== 5'b01111) begin errors++; $display("FAIL super_flush: got %b expected 01111", flush); end
        tick();
        checks++; if (dut.r_pend_q !== 4'd0) begin errors++; $display("FAIL super_pend: got %b expected 0000", dut.r_pend_q); end
    endtask

    task automatic test_counters();
        set_in(5'd0, 5'd0, 1'b1, 1'b0);
        tick();
        for (int n = 0; n < 7; n++) begin
            set_in(5'b00001, 5'd0, 1'b0, 1'b0);
            tick();
        end
        checks++; if (sc !== 4'd7 || sc_nw !== 32'd7) begin errors++; $display("FAIL cnt_seven: got %0d/%0d expected 7", sc, sc_nw); end
        set_in(5'b00001, 5'd0, 1'b1, 1'b0);
        tick();
        checks++; if (sc !== 4'd0 || sc_nw !== 32'd0) begin errors++; $display("FAIL cnt_clr: got %0d/%0d expected 0", sc, sc_nw); end
        for (int n = 0; n < 20; n++) begin
            set_in(5'b00001, 5'd0, 1'b0, 1'b0);
            tick();
        end
        checks++; if (sc !== 4'd15) begin errors++; $display("FAIL cnt_stall_sat: got %0d expected 15", sc); end
        checks++; if (sc_nw !== 32'd20) begin errors++; $display("FAIL cnt_stall_wide: got %0d expected 20", sc_nw); end
        for (int n = 0; n < 20; n++) begin
            set_in(5'd0, 5'b00010, 1'b0, 1'b0);
            tick();
        end
        checks++; if (fc !== 4'd15) begin errors++; $display("FAIL cnt_flush_sat: got %0d expected 15", fc); end
        checks++; if (fc_nw !== 32'(m_fc_nw)) begin errors++; $display("FAIL cnt_flush_wide: got %0d expected %0d", fc_nw, m_fc_nw); end
    endtask

    task automatic test_watchdog();
        set_in(5'd0, 5'd0, 1'b0, 1'b1);
        tick();
        set_in(5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        for (int n = 0; n < 7; n++) begin
            set_in(5'b00100, 5'd0, 1'b0, 1'b0);
            tick();
            checks++; if (hang !== 1'b0) begin errors++; $display("FAIL wd_run1: edge %0d got %b expected 0", n + 1, hang); end
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        for (int n = 0; n < 8; n++) begin
            set_in(5'b00100, 5'd0, 1'b0, 1'b0);
            tick();
            checks++; if (hang !== (n == 7) || hang !== m_hang) begin errors++; $display("FAIL wd_run2: edge %0d got %b expected %b", n + 1, hang, (n == 7)); end
        end
        for (int n = 0; n < 3; n++) begin
            set_in(5'd0, 5'd0, 1'b0, 1'b0);
            tick();
        end
        checks++; if (hang !== 1'b1) begin errors++; $display("FAIL wd_sticky: got %b expected 1", hang); end
        checks++; if (hang_nw !== 1'b0) begin errors++; $display("FAIL wd_disabled: got %b expected 0", hang_nw); end
        set_in(5'd0, 5'd0, 1'b0, 1'b1);
        tick();
        checks++; if (hang !== 1'b0) begin errors++; $display("FAIL wd_rst: got %b expected 0", hang); end
        set_in(5'd0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        set_in(5'b01000, 5'b00100, 1'b0, 1'b0);
        tick();
        checks++; if (dut.r_pend_q !== 4'b0010) begin errors++; $display("FAIL rstmid_pend: got %b expected 0010", dut.r_pend_q); end
        set_in(5'b01000, 5'd0, 1'b0, 1'b1);
        checks++; if (stall !== 5'd0 || flush !== 5'd0) begin errors++; $display("FAIL rstmid_out: got %b %b expected 00000 00000", stall, flush); end
        tick();
        checks++; if (sc !== 4'd0 || fc !== 4'd0 || hang !== 1'b0 || dut.r_pend_q !== 4'd0) begin errors++; $display("FAIL rstmid_state: got %0d %0d %b %b expected 0 0 0 0000", sc, fc, hang, dut.r_pend_q); end
        for (int n = 0; n < 2; n++) begin
            set_in(5'd0, 5'd0, 1'b0, 1'b0);
            checks++; if (flush !== 5'd0) begin errors++; $display("FAIL rstmid_noflush: got %b expected 00000", flush); end
            tick();
        end
    endtask

    task automatic test_random();
        logic [4:0] s, f;
        for (int n = 0; n < 400; n++) begin
            s = 5'($urandom & $urandom & $urandom);
            f = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
            set_in(s, f, ($urandom_range(0, 31) == 0), ($urandom_range(0, 99) == 0));
            checks++; if (stall !== e_stall || stall_nw !== e_stall) begin errors++; $display("FAIL rand_stall: cyc %0d got %b/%b expected %b", n, stall, stall_nw, e_stall); end
            checks++; if (flush !== e_flush || flush_nw !== e_flush) begin errors++; $display("FAIL rand_flush: cyc %0d got %b/%b expected %b", n, flush, flush_nw, e_flush); end
            tick();
            checks++; if (sc !== 4'(m_sc) || fc !== 4'(m_fc)) begin errors++; $display("FAIL rand_cnt: cyc %0d got %0d/%0d expected %0d/%0d", n, sc, fc, m_sc, m_fc); end
            checks++; if (sc_nw !== 32'(m_sc_nw) || fc_nw !== 32'(m_fc_nw)) begin errors++; $display("FAIL rand_cnt_wide: cyc %0d got %0d/%0d expected %0d/%0d", n, sc_nw, fc_nw, m_sc_nw, m_fc_nw); end
            checks++; if (hang !== m_hang || hang_nw !== 1'b0) begin errors++; $display("FAIL rand_hang: cyc %0d got %b/%b expected %b/0", n, hang, hang_nw, m_hang); end
            checks++; if (dut.r_pend_q !== m_pend[4:1]) begin errors++; $display("FAIL rand_pend: cyc %0d got %b expected %b", n, dut.r_pend_q, m_pend[4:1]); end
        end
    endtask

    initial begin
        m_pend = 5'd0; m_sc = 0; m_fc = 0; m_sc_nw = 0; m_fc_nw = 0;
        m_run = 0; m_hang = 1'b0;
        stallreq = 5'd0; flushreq = 5'd0; cnt_clr = 1'b0; rst = 1'b1;
        test_reset();
        test_stall_merge();
        test_immediate_flush();
        test_deferred_flush();
        test_rerequest_supersede();
        test_counters();
        test_watchdog();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
